// File: rtl/vga_map_pkg.sv
// vga_map_pkg: shared widths, map geometry, state and source encodings for the VGA map writer.
package vga_map_pkg;

    localparam int unsigned ADDR_W    = 19;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned MAP_W     = 640;
    localparam int unsigned MAP_H     = 480;
    localparam int unsigned MAP_WORDS = MAP_W * MAP_H;

    typedef enum logic [0:0] {
        ARB   = 1'b0,
        CLEAR = 1'b1
    } state_e;

    localparam logic SRC_RF   = 1'b0;
    localparam logic SRC_DISP = 1'b1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } map_entry_t;

    function automatic logic in_map(input logic [ADDR_W-1:0] addr, input int unsigned words);
        return (32'(addr) < words);
    endfunction

endpackage

// File: rtl/vga_map_writer_if.sv
// vga_map_writer_if: source write strobes, clear control and BRAM port A outputs of the map writer.
interface vga_map_writer_if;
    import vga_map_pkg::*;

    logic              rf_wen;
    logic [ADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0] rf_data;
    logic              disp_wen;
    logic [ADDR_W-1:0] disp_addr;
    logic [DATA_W-1:0] disp_data;
    logic              clear_req;
    logic              clear_busy;
    logic              clear_done;
    logic [ADDR_W-1:0] vga_waddr;
    logic [DATA_W-1:0] dina;
    logic              ena;
    logic              wea;
    logic              ovf_rf;
    logic              ovf_disp;
    logic              oob;

    modport master (
        output rf_wen, rf_addr, rf_data, disp_wen, disp_addr, disp_data, clear_req,
        input  clear_busy, clear_done, vga_waddr, dina, ena, wea, ovf_rf, ovf_disp, oob
    );

    modport slave (
        input  rf_wen, rf_addr, rf_data, disp_wen, disp_addr, disp_data, clear_req,
        output clear_busy, clear_done, vga_waddr, dina, ena, wea, ovf_rf, ovf_disp, oob
    );

endinterface

// File: rtl/vga_map_fifo.sv
// vga_map_fifo: synchronous {addr,data} FIFO; a push into a full FIFO is accepted when a pop
// happens on the same edge.
module vga_map_fifo
    import vga_map_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       push_i,
    input  map_entry_t entry_i,
    input  logic       pop_i,
    output map_entry_t entry_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    map_entry_t       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == (PTR_W+1)'(FIFO_DEPTH));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign entry_o = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + (PTR_W+1)'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; emptiness is tracked by count_q alone.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= entry_i;
        end
    end

endmodule

// File: rtl/vga_map_writer.sv
// vga_map_writer: merges rangefinder and disparity writes into BRAM port A, plus a sweep-clear.
// Define VGA_MAP_RF_PRIORITY_EN to replace round-robin with fixed rangefinder-first arbitration.
module vga_map_writer
    import vga_map_pkg::*;
#(
    parameter int unsigned       FIFO_DEPTH  = 16,
    parameter int unsigned       MAP_WORDS   = vga_map_pkg::MAP_WORDS,
    parameter logic [DATA_W-1:0] CLEAR_VALUE = 8'h00
) (
    input logic             clk,
    input logic             reset,
    vga_map_writer_if.slave mw
);

    localparam logic [0:0]        ST_ARB    = ARB;
    localparam logic [0:0]        ST_CLEAR  = CLEAR;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAP_WORDS - 1);

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              ena_q, ena_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] dina_q, dina_d;
    logic              done_q, done_d;
    logic              ovf_rf_q, ovf_rf_d;
    logic              ovf_disp_q, ovf_disp_d;
    logic              oob_q, oob_d;

    logic              rf_in_map, disp_in_map;
    logic              rf_push, disp_push;
    logic              rf_pop, disp_pop;
    logic              rf_full, rf_empty, disp_full, disp_empty;
    logic              pick_rf, pick_disp;
    logic              arb_go, clear_accept;
    map_entry_t        rf_entry, disp_entry, rf_head, disp_head;

    assign rf_in_map   = in_map(mw.rf_addr, MAP_WORDS);
    assign disp_in_map = in_map(mw.disp_addr, MAP_WORDS);
    assign rf_push     = mw.rf_wen && rf_in_map;
    assign disp_push   = mw.disp_wen && disp_in_map;
    assign rf_entry    = {mw.rf_addr, mw.rf_data};
    assign disp_entry  = {mw.disp_addr, mw.disp_data};

    assign clear_accept = (state_q == ST_ARB) && mw.clear_req;
    assign arb_go       = (state_q == ST_ARB) && !mw.clear_req;
    assign rf_pop       = arb_go && pick_rf;
    assign disp_pop     = arb_go && pick_disp;

    vga_map_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_rf_fifo (
        .clk_i   (clk),
        .rst_i   (reset),
        .push_i  (rf_push),
        .entry_i (rf_entry),
        .pop_i   (rf_pop),
        .entry_o (rf_head),
        .full_o  (rf_full),
        .empty_o (rf_empty)
    );

    vga_map_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_disp_fifo (
        .clk_i   (clk),
        .rst_i   (reset),
        .push_i  (disp_push),
        .entry_i (disp_entry),
        .pop_i   (disp_pop),
        .entry_o (disp_head),
        .full_o  (disp_full),
        .empty_o (disp_empty)
    );

`ifdef VGA_MAP_RF_PRIORITY_EN
    always_comb begin
        pick_rf   = 1'b0;
        pick_disp = 1'b0;
        if (!rf_empty) begin
            pick_rf = 1'b1;
        end else if (!disp_empty) begin
            pick_disp = 1'b1;
        end
    end
`else
    logic rr_q, rr_d;

    // The pointer only advances when both sources competed and a pop really happened.
    always_comb begin
        pick_rf   = 1'b0;
        pick_disp = 1'b0;
        rr_d      = rr_q;
        if (!rf_empty && !disp_empty) begin
            if (rr_q == SRC_RF) begin
                pick_rf = 1'b1;
            end else begin
                pick_disp = 1'b1;
            end
            if (arb_go) begin
                rr_d = ~rr_q;
            end
        end else if (!rf_empty) begin
            pick_rf = 1'b1;
        end else if (!disp_empty) begin
            pick_disp = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_q <= SRC_RF;
        end else begin
            rr_q <= rr_d;
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ena_d      = 1'b0;
        waddr_d    = waddr_q;
        dina_d     = dina_q;
        done_d     = 1'b0;
        ovf_rf_d   = ovf_rf_q;
        ovf_disp_d = ovf_disp_q;
        oob_d      = oob_q;

        if (state_q == ST_CLEAR) begin
            ena_d   = 1'b1;
            waddr_d = cnt_q;
            dina_d  = CLEAR_VALUE;
            if (cnt_q == LAST_ADDR) begin
                state_d = ST_ARB;
                done_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + ADDR_W'(1);
            end
        end else if (clear_accept) begin
            state_d = ST_CLEAR;
            cnt_d   = '0;
        end else if (rf_pop) begin
            ena_d   = 1'b1;
            waddr_d = rf_head.addr;
            dina_d  = rf_head.data;
        end else if (disp_pop) begin
            ena_d   = 1'b1;
            waddr_d = disp_head.addr;
            dina_d  = disp_head.data;
        end

        // Accepting a clear wipes the flags, but events on that same edge still register.
        if (clear_accept) begin
            ovf_rf_d   = 1'b0;
            ovf_disp_d = 1'b0;
            oob_d      = 1'b0;
        end
        if ((mw.rf_wen && !rf_in_map) || (mw.disp_wen && !disp_in_map)) begin
            oob_d = 1'b1;
        end
        if (rf_push && rf_full && !rf_pop) begin
            ovf_rf_d = 1'b1;
        end
        if (disp_push && disp_full && !disp_pop) begin
            ovf_disp_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_ARB;
            cnt_q      <= '0;
            ena_q      <= 1'b0;
            waddr_q    <= '0;
            dina_q     <= '0;
            done_q     <= 1'b0;
            ovf_rf_q   <= 1'b0;
            ovf_disp_q <= 1'b0;
            oob_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ena_q      <= ena_d;
            waddr_q    <= waddr_d;
            dina_q     <= dina_d;
            done_q     <= done_d;
            ovf_rf_q   <= ovf_rf_d;
            ovf_disp_q <= ovf_disp_d;
            oob_q      <= oob_d;
        end
    end

    assign mw.clear_busy = (state_q == ST_CLEAR);
    assign mw.clear_done = done_q;
    assign mw.vga_waddr  = waddr_q;
    assign mw.dina       = dina_q;
    assign mw.ena        = ena_q;
    assign mw.wea        = ena_q;
    assign mw.ovf_rf     = ovf_rf_q;
    assign mw.ovf_disp   = ovf_disp_q;
    assign mw.oob        = oob_q;

endmodule

// File: tb/tb_vga_map_writer.sv
// tb_vga_map_writer: directed stimulus for the map writer, checked every cycle against a
// queue-based model of the two sources, the arbiter and the sweep-clear.
`timescale 1ns/1ps
module tb_vga_map_writer;
    import vga_map_pkg::*;

    localparam int                TB_DEPTH = 16;
    localparam int                TB_WORDS = 2000;
    localparam logic [DATA_W-1:0] TB_CLR   = 8'h00;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } ent_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vga_map_writer_if mw ();

    vga_map_writer #(
        .FIFO_DEPTH  (TB_DEPTH),
        .MAP_WORDS   (TB_WORDS),
        .CLEAR_VALUE (TB_CLR)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .mw    (mw)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask

    // Model state: what the map writer must hold and drive after each edge.
    ent_t              mq_rf[$];
    ent_t              mq_dp[$];
    bit                m_clear = 1'b0;
    int                m_cnt   = 0;
    bit                m_ptr   = 1'b0;
    bit                e_ena   = 1'b0;
    logic [ADDR_W-1:0] e_addr  = '0;
    logic [DATA_W-1:0] e_data  = '0;
    bit                e_done  = 1'b0;
    bit                e_ovf_rf = 1'b0;
    bit                e_ovf_dp = 1'b0;
    bit                e_oob   = 1'b0;
    bit                chk_en  = 1'b0;

    always @(posedge clk) begin : model
        ent_t ent;
        bit   take;
        take = 1'b0;
        ent  = '0;
        if (reset) begin
            mq_rf.delete();
            mq_dp.delete();
            m_clear  = 1'b0;
            m_cnt    = 0;
            m_ptr    = 1'b0;
            e_ena    = 1'b0;
            e_done   = 1'b0;
            e_ovf_rf = 1'b0;
            e_ovf_dp = 1'b0;
            e_oob    = 1'b0;
            chk_en   = 1'b1;
        end else begin
            e_done = 1'b0;
            if (m_clear) begin
                e_ena  = 1'b1;
                e_addr = ADDR_W'(m_cnt);
                e_data = TB_CLR;
                if (m_cnt == TB_WORDS - 1) begin
                    m_clear = 1'b0;
                    e_done  = 1'b1;
                end else begin
                    m_cnt++;
                end
            end else if (mw.clear_req) begin
                m_clear  = 1'b1;
                m_cnt    = 0;
                e_ena    = 1'b0;
                e_ovf_rf = 1'b0;
                e_ovf_dp = 1'b0;
                e_oob    = 1'b0;
            end else begin
`ifdef VGA_MAP_RF_PRIORITY_EN
                if (mq_rf.size() > 0) begin
                    ent = mq_rf.pop_front(); take = 1'b1;
                end else if (mq_dp.size() > 0) begin
                    ent = mq_dp.pop_front(); take = 1'b1;
                end
`else
                if (mq_rf.size() > 0 && mq_dp.size() > 0) begin
                    if (!m_ptr) ent = mq_rf.pop_front();
                    else        ent = mq_dp.pop_front();
                    m_ptr = !m_ptr;
                    take  = 1'b1;
                end else if (mq_rf.size() > 0) begin
                    ent = mq_rf.pop_front(); take = 1'b1;
                end else if (mq_dp.size() > 0) begin
                    ent = mq_dp.pop_front(); take = 1'b1;
                end
`endif
                e_ena = take;
                if (take) begin
                    e_addr = ent.a;
                    e_data = ent.d;
                end
            end
            if (mw.rf_wen) begin
                if (int'(mw.rf_addr) >= TB_WORDS) e_oob = 1'b1;
                else if (mq_rf.size() < TB_DEPTH) mq_rf.push_back({mw.rf_addr, mw.rf_data});
                else e_ovf_rf = 1'b1;
            end
            if (mw.disp_wen) begin
                if (int'(mw.disp_addr) >= TB_WORDS) e_oob = 1'b1;
                else if (mq_dp.size() < TB_DEPTH) mq_dp.push_back({mw.disp_addr, mw.disp_data});
                else e_ovf_dp = 1'b1;
            end
        end
    end

    // Observation bookkeeping used by the directed literal checks.
    logic [ADDR_W-1:0] wlog[$];
    bit                hit [TB_WORDS];
    int                busy_cnt = 0;
    int                done_cnt = 0;
    int                clr_wr   = 0;
    int                distinct = 0;
    bit                prev_busy = 1'b0;
    bit                prev_done = 1'b0;
    logic [ADDR_W-1:0] after_done_addr = '1;

    always @(negedge clk) begin
        if (chk_en) begin
            check("ena", 32'(mw.ena), 32'(e_ena));
            check("wea", 32'(mw.wea), 32'(e_ena));
            if (e_ena) begin
                check("vga_waddr", 32'(mw.vga_waddr), 32'(e_addr));
                check("dina", 32'(mw.dina), 32'(e_data));
            end
            check("clear_busy", 32'(mw.clear_busy), 32'(m_clear));
            check("clear_done", 32'(mw.clear_done), 32'(e_done));
            check("ovf_rf", 32'(mw.ovf_rf), 32'(e_ovf_rf));
            check("ovf_disp", 32'(mw.ovf_disp), 32'(e_ovf_dp));
            check("oob", 32'(mw.oob), 32'(e_oob));

            if (mw.clear_busy === 1'b1) busy_cnt++;
            if (mw.clear_done === 1'b1) done_cnt++;
            if (mw.ena === 1'b1) begin
                if (prev_busy) begin
                    clr_wr++;
                    if (int'(mw.vga_waddr) < TB_WORDS && !hit[int'(mw.vga_waddr)]) begin
                        hit[int'(mw.vga_waddr)] = 1'b1;
                        distinct++;
                    end
                end else begin
                    wlog.push_back(mw.vga_waddr);
                    if (prev_done) after_done_addr = mw.vga_waddr;
                end
            end
            prev_busy = (mw.clear_busy === 1'b1);
            prev_done = (mw.clear_done === 1'b1);
        end
    end

    task automatic drive(input bit rw, input int ra, input int rd, input bit dw, input int da, input int dd);
        mw.rf_wen    = rw;
        mw.rf_addr   = ADDR_W'(ra);
        mw.rf_data   = DATA_W'(rd);
        mw.disp_wen  = dw;
        mw.disp_addr = ADDR_W'(da);
        mw.disp_data = DATA_W'(dd);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_clear();
        mw.clear_req = 1'b1;
        @(negedge clk);
        mw.clear_req = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (done_cnt == 0 && n < TB_WORDS + 50) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(done_cnt > 0), 32'd1);
    endtask

    task automatic reset_counts();
        busy_cnt = 0; done_cnt = 0; clr_wr = 0; distinct = 0;
        after_done_addr = '1;
        foreach (hit[i]) hit[i] = 1'b0;
        wlog.delete();
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog timeout");
    end

    initial begin : stim
        int n;
        int dcount;
        int dmax;
        reset = 1'b1;
        mw.clear_req = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        tick(3);
        check("reset_ena", 32'(mw.ena), 32'd0);
        check("reset_waddr", 32'(mw.vga_waddr), 32'd0);
        check("reset_dina", 32'(mw.dina), 32'd0);
        check("reset_busy", 32'(mw.clear_busy), 32'd0);
        reset = 1'b0;

        // Single rangefinder write: visible one edge after the push edge, not before.
        drive(1, 1699, 'hFF, 0, 0, 0);
        tick(1);
        check("single_no_bypass", 32'(mw.ena), 32'd0);
        drive(0, 0, 0, 0, 0, 0);
        tick(1);
        check("single_ena", 32'(mw.ena), 32'd1);
        check("single_addr", 32'(mw.vga_waddr), 32'd1699);
        check("single_data", 32'(mw.dina), 32'hFF);
        check("single_ovf_rf", 32'(mw.ovf_rf), 32'd0);
        tick(3);

        // Contention: eight cycles of simultaneous writes from both sources.
        wlog.delete();
        for (int i = 0; i < 8; i++) begin
            drive(1, 100 + i, i, 1, 200 + i, 'h80 + i);
            tick(1);
        end
        drive(0, 0, 0, 0, 0, 0);
        tick(20);
        check("cont_count", 32'(wlog.size()), 32'd16);
`ifdef VGA_MAP_RF_PRIORITY_EN
        check("cont_w1", 32'(wlog[1]), 32'd101);
        check("cont_w3", 32'(wlog[3]), 32'd103);
        check("cont_w8", 32'(wlog[8]), 32'd200);
`else
        check("cont_w1", 32'(wlog[1]), 32'd200);
        check("cont_w3", 32'(wlog[3]), 32'd201);
        check("cont_w8", 32'(wlog[8]), 32'd104);
`endif
        check("cont_flags", 32'({mw.ovf_rf, mw.ovf_disp, mw.oob}), 32'd0);

        // Twenty cycles of both sources while arbitrating.
        for (int i = 0; i < 20; i++) begin
            drive(1, 300 + i, i, 1, 500 + i, i);
            tick(1);
        end
        drive(0, 0, 0, 0, 0, 0);
        tick(50);
`ifdef VGA_MAP_RF_PRIORITY_EN
        check("arb20_ovf_disp", 32'(mw.ovf_disp), 32'd1);
`else
        check("arb20_ovf_disp", 32'(mw.ovf_disp), 32'd0);
`endif

        // Out-of-bounds address is discarded and flagged.
        drive(1, TB_WORDS, 'h11, 0, 0, 0);
        tick(1);
        drive(0, 0, 0, 0, 0, 0);
        check("oob_set", 32'(mw.oob), 32'd1);
        tick(1);
        check("oob_no_write", 32'(mw.ena), 32'd0);
        tick(3);

        // Sweep-clear A with three rangefinder writes and an ignored clear_req mid-sweep.
        reset_counts();
        pulse_clear();
        check("clearA_busy", 32'(mw.clear_busy), 32'd1);
        check("clearA_oob_cleared", 32'(mw.oob), 32'd0);
        tick(500);
        for (int i = 0; i < 3; i++) begin
            drive(1, 11 + i, 'hA1 + i, 0, 0, 0);
            tick(1);
        end
        drive(0, 0, 0, 0, 0, 0);
        tick(300);
        pulse_clear();
        wait_done("clearA_done_seen");
        tick(10);
        check("clearA_busy_cycles", 32'(busy_cnt), 32'(TB_WORDS));
        check("clearA_writes", 32'(clr_wr), 32'(TB_WORDS));
        check("clearA_distinct", 32'(distinct), 32'(TB_WORDS));
        check("clearA_done_pulses", 32'(done_cnt), 32'd1);
        check("clearA_first_after_done", 32'(after_done_addr), 32'd11);
        check("clearA_src_writes", 32'(wlog.size()), 32'd3);

        // Sweep-clear B: both sources overflow while nothing is popped.
        reset_counts();
        pulse_clear();
        tick(100);
        for (int i = 0; i < 20; i++) begin
            drive(1, 600 + i, i, 1, 700 + i, i);
            tick(1);
        end
        drive(0, 0, 0, 0, 0, 0);
        wait_done("clearB_done_seen");
        tick(60);
        check("clearB_ovf_disp", 32'(mw.ovf_disp), 32'd1);
        check("clearB_ovf_rf", 32'(mw.ovf_rf), 32'd1);
        dcount = 0;
        dmax = 0;
        foreach (wlog[i]) begin
            if (int'(wlog[i]) >= 700 && int'(wlog[i]) < 720) begin
                dcount++;
                if (int'(wlog[i]) > dmax) dmax = int'(wlog[i]);
            end
        end
        check("clearB_disp_kept", 32'(dcount), 32'd16);
        check("clearB_disp_last", 32'(dmax), 32'd715);
        check("clearB_total_drain", 32'(wlog.size()), 32'd32);

        // Sweep-clear C aborted by reset with the counter at 1000.
        reset_counts();
        pulse_clear();
        tick(100);
        for (int i = 0; i < 3; i++) begin
            drive(1, 40 + i, i, 0, 0, 0);
            tick(1);
        end
        drive(0, 0, 0, 0, 0, 0);
        n = 0;
        while (!(m_clear && m_cnt == 1000) && n < TB_WORDS) begin
            @(negedge clk);
            n++;
        end
        check("clearC_reached_1000", 32'(m_cnt), 32'd1000);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("abort_ena", 32'(mw.ena), 32'd0);
        check("abort_busy", 32'(mw.clear_busy), 32'd0);
        check("abort_waddr", 32'(mw.vga_waddr), 32'd0);
        tick(TB_WORDS);
        check("abort_no_done", 32'(done_cnt), 32'd0);
        check("abort_fifo_empty", 32'(wlog.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
